// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
// Holds the widths, the iteration count and the controller state encoding.
package div_pkg;

    localparam int WIDTH = 8;
    localparam int ITER  = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        SHIFT = 3'd2,
        TRIAL = 3'd3,
        HOLD  = 3'd4
    } state_t;

endpackage

// File: rtl/div_trial_sub.sv
// Trial subtraction for one restoring-division step.
// Produces R minus the zero-extended divisor and a flag for R >= D.
module div_trial_sub #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   r,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH:0]   diff,
    output logic             ge
);

    assign diff = r - {1'b0, d};
    assign ge   = (r >= {1'b0, d});

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one shift and one trial cycle per quotient bit.
// The divisor is loaded ahead of time with calb; run latches the dividend and starts.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = div_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             calb,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(ITER);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

    state_t             state, state_next;
    logic [WIDTH-1:0]   q, q_next;
    logic [WIDTH:0]     r, r_next;
    logic [WIDTH-1:0]   d, d_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic               dbz, dbz_next;
    logic [WIDTH:0]     diff;
    logic               ge;

    div_trial_sub #(.WIDTH(WIDTH)) u_trial (
        .r    (r),
        .d    (d),
        .diff (diff),
        .ge   (ge)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            q     <= '0;
            r     <= '0;
            d     <= '0;
            cnt   <= '0;
            dbz   <= 1'b0;
        end else begin
            state <= state_next;
            q     <= q_next;
            r     <= r_next;
            d     <= d_next;
            cnt   <= cnt_next;
            dbz   <= dbz_next;
        end
    end

    // A zero divisor takes no special path: every trial succeeds, giving all-ones Q and R = dividend.
    always_comb begin
        state_next = state;
        q_next     = q;
        r_next     = r;
        d_next     = d;
        cnt_next   = cnt;
        dbz_next   = dbz;
        case (state)
            IDLE: begin
                if (run) begin
                    state_next = INIT;
                end else if (calb) begin
                    d_next = din;
                end
            end
            INIT: begin
                q_next     = din;
                r_next     = '0;
                cnt_next   = '0;
                dbz_next   = (d == '0);
                state_next = SHIFT;
            end
            SHIFT: begin
                r_next     = {r[WIDTH-1:0], q[WIDTH-1]};
                q_next     = {q[WIDTH-2:0], 1'b0};
                state_next = TRIAL;
            end
            TRIAL: begin
                if (ge) begin
                    r_next    = diff;
                    q_next[0] = 1'b1;
                end
                if (cnt == LAST_CNT) begin
                    state_next = HOLD;
                end else begin
                    cnt_next   = cnt + 1'b1;
                    state_next = SHIFT;
                end
            end
            HOLD: begin
                if (!run) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            INIT, SHIFT, TRIAL: busy = 1'b1;
            HOLD:               done = 1'b1;
            default:            ;
        endcase
    end

    assign quotient    = q;
    assign remainder   = r[WIDTH-1:0];
    assign divisor     = d;
    assign div_by_zero = dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: a table of divides plus hand-written
// sequences for zero divisor, mid-run reset, held run and early run release.
module tb_seq_divider;

    logic       clk;
    logic       reset;
    logic       run;
    logic       calb;
    logic [7:0] din;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic       div_by_zero;

    int tests_run;
    int tests_failed;

    typedef struct {
        logic [7:0] dvs;
        logic [7:0] dvd;
        logic [7:0] exp_q;
        logic [7:0] exp_r;
        logic       exp_dbz;
    } vec_t;

    vec_t vecs[7];

    seq_divider dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .calb        (calb),
        .din         (din),
        .quotient    (quotient),
        .remainder   (remainder),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Loads the divisor, then starts a divide and counts edges after edge 0 until done.
    task automatic apply_stimulus(input logic [7:0] dvs, input logic [7:0] dvd, input logic do_calb, output int edges);
        if (do_calb) begin
            calb = 1'b1;
            din  = dvs;
            tick();
            calb = 1'b0;
        end
        run = 1'b1;
        din = dvd;
        tick();
        edges = 0;
        while (!done && edges < 40) begin
            tick();
            edges++;
        end
    endtask

    task automatic release_run();
        run = 1'b0;
        tick();
    endtask

    initial begin
        int edges;
        tests_run    = 0;
        tests_failed = 0;
        reset = 1'b1;
        run   = 1'b0;
        calb  = 1'b0;
        din   = 8'd0;

        vecs[0] = '{8'd7,   8'd100, 8'd14,  8'd2,   1'b0};
        vecs[1] = '{8'd1,   8'd255, 8'd255, 8'd0,   1'b0};
        vecs[2] = '{8'd9,   8'd5,   8'd0,   8'd5,   1'b0};
        vecs[3] = '{8'd255, 8'd254, 8'd0,   8'd254, 1'b0};
        vecs[4] = '{8'd16,  8'd255, 8'd15,  8'd15,  1'b0};
        vecs[5] = '{8'd3,   8'd10,  8'd3,   8'd1,   1'b0};
        vecs[6] = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0};

        #12;
        check_output("reset_quotient", quotient, 0);
        check_output("reset_remainder", remainder, 0);
        check_output("reset_divisor", divisor, 0);
        check_output("reset_busy", busy, 0);
        check_output("reset_done", done, 0);
        check_output("reset_dbz", div_by_zero, 0);
        reset = 1'b0;
        tick();

        // Zero divisor straight after reset, dividend 200.
        apply_stimulus(8'd0, 8'd200, 1'b0, edges);
        check_output("dz_edges", edges, 17);
        check_output("dz_quotient", quotient, 8'hFF);
        check_output("dz_remainder", remainder, 200);
        check_output("dz_flag", div_by_zero, 1);
        release_run();
        check_output("dz_flag_held_idle", div_by_zero, 1);

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].dvs, vecs[i].dvd, 1'b1, edges);
            check_output($sformatf("vec%0d_edges", i), edges, 17);
            check_output($sformatf("vec%0d_quotient", i), quotient, vecs[i].exp_q);
            check_output($sformatf("vec%0d_remainder", i), remainder, vecs[i].exp_r);
            check_output($sformatf("vec%0d_dbz", i), div_by_zero, vecs[i].exp_dbz);
            check_output($sformatf("vec%0d_divisor", i), divisor, vecs[i].dvs);
            release_run();
            check_output($sformatf("vec%0d_idle_done", i), done, 0);
            check_output($sformatf("vec%0d_idle_quotient", i), quotient, vecs[i].exp_q);
        end

        // Busy must be low before edge 0 and high after it; done must not be early.
        calb = 1'b1;
        din  = 8'd7;
        tick();
        calb = 1'b0;
        check_output("pre_busy", busy, 0);
        run = 1'b1;
        din = 8'd100;
        tick();
        check_output("edge0_busy", busy, 1);
        for (int i = 1; i <= 16; i++) tick();
        check_output("edge16_done", done, 0);
        check_output("edge16_busy", busy, 1);
        tick();
        check_output("edge17_done", done, 1);
        check_output("edge17_busy", busy, 0);

        // Held run in HOLD: no restart, calb ignored.
        calb = 1'b1;
        din  = 8'd50;
        for (int i = 0; i < 4; i++) tick();
        check_output("hold_done", done, 1);
        check_output("hold_divisor", divisor, 7);
        check_output("hold_quotient", quotient, 14);
        check_output("hold_remainder", remainder, 2);
        calb = 1'b0;
        release_run();
        check_output("hold_exit_done", done, 0);
        check_output("hold_exit_busy", busy, 0);
        apply_stimulus(8'd0, 8'd50, 1'b0, edges);
        check_output("rerun_edges", edges, 17);
        check_output("rerun_quotient", quotient, 7);
        check_output("rerun_remainder", remainder, 1);
        release_run();

        // Asynchronous reset between edges 8 and 9.
        calb = 1'b1;
        din  = 8'd9;
        tick();
        calb = 1'b0;
        run = 1'b1;
        din = 8'd77;
        tick();
        for (int i = 1; i <= 8; i++) tick();
        check_output("midrun_busy", busy, 1);
        run = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_output("areset_quotient", quotient, 0);
        check_output("areset_remainder", remainder, 0);
        check_output("areset_divisor", divisor, 0);
        check_output("areset_busy", busy, 0);
        check_output("areset_done", done, 0);
        check_output("areset_dbz", div_by_zero, 0);
        #1;
        reset = 1'b0;
        tick();
        check_output("post_reset_busy", busy, 0);
        apply_stimulus(8'd9, 8'd77, 1'b1, edges);
        check_output("post_reset_edges", edges, 17);
        check_output("post_reset_quotient", quotient, 8);
        check_output("post_reset_remainder", remainder, 5);
        release_run();

        // Run dropped after edge 5: completes, HOLD lasts one cycle.
        calb = 1'b1;
        din  = 8'd13;
        tick();
        calb = 1'b0;
        run = 1'b1;
        din = 8'd200;
        tick();
        for (int i = 1; i <= 5; i++) tick();
        run = 1'b0;
        edges = 5;
        while (!done && edges < 40) begin
            tick();
            edges++;
        end
        check_output("drop_edges", edges, 17);
        check_output("drop_quotient", quotient, 15);
        check_output("drop_remainder", remainder, 5);
        tick();
        check_output("drop_hold_one_cycle", done, 0);
        check_output("drop_idle_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; all requirements below use WIDTH=8.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 run  input  1  level start request; sampled only in IDLE and HOLD.
REQ-005 calb  input  1  load divisor from din; honoured only in IDLE.
REQ-006 din  input  8  switch data: divisor when calb, dividend when run starts.
REQ-007 quotient  output  8  quotient register (Q).
REQ-008 remainder  output  8  low 8 bits of remainder register (R).
REQ-009 divisor  output  8  divisor register (D), for display.
REQ-010 busy  output  1  high in INIT, SHIFT, TRIAL.
REQ-011 done  output  1  high only in HOLD.
REQ-012 div_by_zero  output  1  set at INIT when D==0; held until next INIT or reset.

Function
REQ-013 Unsigned restoring division, Q = dividend / D, R = dividend mod D; internal R is 9 bits (WIDTH+1) so 2R+1 never overflows.
REQ-014 States: IDLE, INIT, SHIFT, TRIAL, HOLD; 3-bit iteration counter cnt.
REQ-015 IDLE: calb=1 -> D<=din; run=1 -> INIT (run has priority: if run and calb are both high, D is not loaded); otherwise stay.
REQ-016 INIT: Q<=din, R<=0, cnt<=0, div_by_zero<=(D==0) -> SHIFT.
REQ-017 SHIFT: {R,Q} shifted left one bit, Q[0]<=0 -> TRIAL.
REQ-018 TRIAL: if R>=D then R<=R-D and Q[0]<=1, else R and Q unchanged; cnt==7 -> HOLD, else cnt<=cnt+1 -> SHIFT.
REQ-019 HOLD: Q, R and D frozen; run=0 -> IDLE, else stay (no restart while run remains high).
REQ-020 Latency: the edge that samples run=1 in IDLE is edge 0; HOLD entered on edge 17; done first high in the cycle after edge 17.
REQ-021 D==0: no special path; full 16-cycle iteration runs and yields Q=8'hFF, R=dividend, div_by_zero=1.
REQ-022 run deasserted during INIT/SHIFT/TRIAL: ignored; operation completes, then HOLD exits to IDLE on the next edge.
REQ-023 calb outside IDLE: ignored; D never changes while busy or done.
REQ-024 Q and R retain the last result in IDLE until the next INIT.

Reset
REQ-025 reset=1 immediately forces state=IDLE, cnt=0, Q=0, R=0, D=0, busy=0, done=0, div_by_zero=0, regardless of clock.
REQ-026 reset asserted mid-operation aborts the division; no partial result is retained.
REQ-027 After reset is released, the first run requires run sampled high in IDLE; a run held high through reset starts on the first edge after release.

Structure
REQ-028 Package div_pkg holds the state enum typedef, WIDTH=8 and ITER=8.
REQ-029 Sub-module div_trial_sub: combinational 9-bit R minus zero-extended D, producing diff[8:0] and ge (R>=D); instantiated once.
REQ-030 Next-state logic and output decode are combinational; every combinational output has a default assignment, with no inferred latches.

Verification
REQ-031 calb with din=7, then run with din=100 -> after 18 edges done=1, quotient=14, remainder=2, div_by_zero=0.
REQ-032 D=1, dividend=255 -> quotient=255, remainder=0; D=9, dividend=5 -> quotient=0, remainder=5.
REQ-033 D=0 (post-reset), dividend=200 -> quotient=8'hFF, remainder=200, div_by_zero=1, done on the same edge count as a normal divide.
REQ-034 reset pulsed asynchronously between edges 8 and 9 -> all outputs 0 immediately, state IDLE; a new run gives a correct result.
REQ-035 run held high after done, calb toggled in HOLD -> no restart, D unchanged; run low -> IDLE; run high again -> new divide.
REQ-036 run dropped at edge 5 -> divide completes with correct result, HOLD lasts exactly one cycle, then IDLE.
